// File: rtl/regbank_arbiter.sv
// Two-requester round-robin arbiter for a toggle-handshake register bank; one transaction in flight.
// Optional WAIT timeout with sticky err and a terminal ERR state: define REGBANK_ARB_TIMEOUT_EN.
module regbank_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              trigger0,
    input  logic [ADDR_W-1:0] addr0,
    output logic              ready0,
    output logic [DATA_W-1:0] data0,
    input  logic              trigger1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              ready1,
    output logic [DATA_W-1:0] data1,
    output logic              triggerOutRB,
    output logic [ADDR_W-1:0] addrRB,
    input  logic              readyInRB,
    input  logic [DATA_W-1:0] dataInRB,
    output logic              grant,
    output logic              busy,
    output logic              err
);

`ifdef REGBANK_ARB_TIMEOUT_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_ERR = 2'd2} state_t;
`else
    typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;
`endif

    state_t            state_q, state_d;
    logic              trig_q, trig_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rdy0_q, rdy0_d, rdy1_q, rdy1_d;
    logic [DATA_W-1:0] dat0_q, dat0_d, dat1_q, dat1_d;
    logic              grant_q, grant_d;
    logic              last_q, last_d;
    logic              pend0, pend1, pick, complete, timeout;

    assign pend0    = (trigger0 != rdy0_q);
    assign pend1    = (trigger1 != rdy1_q);
    // On a tie the requester not served last wins; otherwise the lone requester wins.
    assign pick     = (pend0 && pend1) ? ~last_q : pend1;
    assign complete = (readyInRB == trig_q);

`ifdef REGBANK_ARB_TIMEOUT_EN
    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0]      TO_DATA  = 32'hDEADBEEF;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    assign timeout = (state_q == S_WAIT) && !complete && (cnt_q == CNT_LAST);
    assign err     = err_q;
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            trig_q  <= 1'b0;
            addr_q  <= '0;
            rdy0_q  <= 1'b0;
            rdy1_q  <= 1'b0;
            dat0_q  <= '0;
            dat1_q  <= '0;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
`ifdef REGBANK_ARB_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            trig_q  <= trig_d;
            addr_q  <= addr_d;
            rdy0_q  <= rdy0_d;
            rdy1_q  <= rdy1_d;
            dat0_q  <= dat0_d;
            dat1_q  <= dat1_d;
            grant_q <= grant_d;
            last_q  <= last_d;
`ifdef REGBANK_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (pend0 || pend1) state_d = S_WAIT;
            S_WAIT: begin
                if (complete)     state_d = S_IDLE;
`ifdef REGBANK_ARB_TIMEOUT_EN
                else if (timeout) state_d = S_ERR;
            end
            S_ERR: begin
                state_d = S_ERR;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        trig_d  = trig_q;
        addr_d  = addr_q;
        rdy0_d  = rdy0_q;
        rdy1_d  = rdy1_q;
        dat0_d  = dat0_q;
        dat1_d  = dat1_q;
        grant_d = grant_q;
        last_d  = last_q;
        if (state_q == S_IDLE && (pend0 || pend1)) begin
            grant_d = pick;
            last_d  = pick;
            addr_d  = pick ? addr1 : addr0;
            trig_d  = ~trig_q;
        end
        if (state_q == S_WAIT && complete) begin
            if (grant_q) begin
                rdy1_d = ~rdy1_q;
                dat1_d = dataInRB;
            end else begin
                rdy0_d = ~rdy0_q;
                dat0_d = dataInRB;
            end
        end
`ifdef REGBANK_ARB_TIMEOUT_EN
        err_d = err_q;
        // Counter sits at zero outside WAIT so it is already cleared on entry.
        cnt_d = (state_q == S_WAIT) ? cnt_q + 1'b1 : '0;
        if (timeout) begin
            err_d = 1'b1;
            if (grant_q) begin
                rdy1_d = ~rdy1_q;
                dat1_d = DATA_W'(TO_DATA);
            end else begin
                rdy0_d = ~rdy0_q;
                dat0_d = DATA_W'(TO_DATA);
            end
        end
`endif
    end

    assign triggerOutRB = trig_q;
    assign addrRB       = addr_q;
    assign ready0       = rdy0_q;
    assign ready1       = rdy1_q;
    assign data0        = dat0_q;
    assign data1        = dat1_q;
    assign grant        = grant_q;
    assign busy         = (state_q == S_WAIT);

endmodule

// File: tb/tb_regbank_arbiter.sv
// Bench for regbank_arbiter: directed vector table, fairness sequence, random run against a transaction model.
module tb_regbank_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          trigger0, trigger1, readyInRB;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] dataInRB;
    logic          ready0, ready1, triggerOutRB, grant, busy, err;
    logic [DW-1:0] data0, data1;
    logic [AW-1:0] addrRB;

    always #5 clk = ~clk;

    regbank_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset(reset),
        .trigger0(trigger0), .addr0(addr0), .ready0(ready0), .data0(data0),
        .trigger1(trigger1), .addr1(addr1), .ready1(ready1), .data1(data1),
        .triggerOutRB(triggerOutRB), .addrRB(addrRB),
        .readyInRB(readyInRB), .dataInRB(dataInRB),
        .grant(grant), .busy(busy), .err(err)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic          rst, t0;
        logic [31:0]   a0;
        logic          t1;
        logic [31:0]   a1;
        logic          rbr;
        logic [31:0]   rbd;
        logic          e_trig;
        logic [31:0]   e_addr;
        logic          e_r0;
        logic [31:0]   e_d0;
        logic          e_r1;
        logic [31:0]   e_d1;
        logic          e_g, e_busy;
    } vec_t;

    function automatic vec_t mk(input logic rst, t0, input logic [31:0] a0, input logic t1,
                                input logic [31:0] a1, input logic rbr, input logic [31:0] rbd,
                                input logic et, input logic [31:0] ea, input logic er0,
                                input logic [31:0] ed0, input logic er1, input logic [31:0] ed1,
                                input logic eg, eb);
        vec_t v;
        v.rst = rst; v.t0 = t0; v.a0 = a0; v.t1 = t1; v.a1 = a1; v.rbr = rbr; v.rbd = rbd;
        v.e_trig = et; v.e_addr = ea; v.e_r0 = er0; v.e_d0 = ed0; v.e_r1 = er1; v.e_d1 = ed1;
        v.e_g = eg; v.e_busy = eb;
        return v;
    endfunction

    task automatic do_reset();
        reset = 1'b1; trigger0 = 1'b0; trigger1 = 1'b0; addr0 = '0; addr1 = '0;
        readyInRB = 1'b0; dataInRB = '0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    vec_t vecs[15];
    int   gseq[8];

    // Transaction-level reference state for the random run.
    logic          e_trig, e_r0, e_r1, e_g, m_busy, m_last, p0, p1, g;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_d0, e_d1;
    int            rb_wait;

    initial begin
        reset = 1'b1; trigger0 = 1'b0; trigger1 = 1'b0; addr0 = '0; addr1 = '0;
        readyInRB = 1'b0; dataInRB = '0;

        //           rst t0 a0 t1 a1 rbr rbd          trig addr r0 d0        r1 d1        g busy
        vecs[0]  = mk(1, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0,            0, 0,        0, 0);
        vecs[1]  = mk(0, 1, 5, 0, 0, 0, 0,            1, 5, 0, 0,            0, 0,        0, 1);
        vecs[2]  = mk(0, 1, 5, 0, 0, 0, 0,            1, 5, 0, 0,            0, 0,        0, 1);
        vecs[3]  = mk(0, 1, 5, 0, 0, 1, 32'h1234,     1, 5, 1, 32'h1234,     0, 0,        0, 0);
        vecs[4]  = mk(0, 1, 9, 0, 0, 1, 32'h1234,     1, 5, 1, 32'h1234,     0, 0,        0, 0);
        vecs[5]  = mk(1, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0,            0, 0,        0, 0);
        vecs[6]  = mk(0, 1, 1, 1, 2, 0, 0,            1, 1, 0, 0,            0, 0,        0, 1);
        vecs[7]  = mk(0, 1, 7, 1, 2, 1, 32'hAAAA,     1, 1, 1, 32'hAAAA,     0, 0,        0, 0);
        vecs[8]  = mk(0, 1, 7, 1, 2, 1, 32'hAAAA,     0, 2, 1, 32'hAAAA,     0, 0,        1, 1);
        vecs[9]  = mk(0, 1, 7, 1, 2, 0, 32'hBBBB,     0, 2, 1, 32'hAAAA,     1, 32'hBBBB, 1, 0);
        vecs[10] = mk(0, 1, 7, 1, 2, 0, 32'hBBBB,     0, 2, 1, 32'hAAAA,     1, 32'hBBBB, 1, 0);
        vecs[11] = mk(0, 0, 7, 1, 2, 0, 32'hBBBB,     1, 7, 1, 32'hAAAA,     1, 32'hBBBB, 0, 1);
        vecs[12] = mk(1, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0,            0, 0,        0, 0);
        vecs[13] = mk(0, 1, 3, 0, 0, 0, 0,            1, 3, 0, 0,            0, 0,        0, 1);
        vecs[14] = mk(0, 1, 3, 0, 0, 1, 32'h55,       1, 3, 1, 32'h55,       0, 0,        0, 0);

        @(negedge clk);
        for (int i = 0; i < 15; i++) begin
            reset = vecs[i].rst; trigger0 = vecs[i].t0; addr0 = vecs[i].a0;
            trigger1 = vecs[i].t1; addr1 = vecs[i].a1;
            readyInRB = vecs[i].rbr; dataInRB = vecs[i].rbd;
            @(negedge clk);
            check($sformatf("v%0d trig", i),  triggerOutRB, vecs[i].e_trig);
            check($sformatf("v%0d addr", i),  addrRB,       vecs[i].e_addr);
            check($sformatf("v%0d rdy0", i),  ready0,       vecs[i].e_r0);
            check($sformatf("v%0d dat0", i),  data0,        vecs[i].e_d0);
            check($sformatf("v%0d rdy1", i),  ready1,       vecs[i].e_r1);
            check($sformatf("v%0d dat1", i),  data1,        vecs[i].e_d1);
            check($sformatf("v%0d grant", i), grant,        vecs[i].e_g);
            check($sformatf("v%0d busy", i),  busy,         vecs[i].e_busy);
            check($sformatf("v%0d err", i),   err,          1'b0);
        end

        // Both requesters re-request continuously; zero-latency regbank.
        begin
            int   n = 0;
            logic prev = 1'b0;
            do_reset();
            for (int c = 0; c < 100 && n < 8; c++) begin
                if (triggerOutRB != prev) begin
                    gseq[n] = int'(grant);
                    n++;
                    prev = triggerOutRB;
                end
                if (trigger0 == ready0) trigger0 = ~trigger0;
                if (trigger1 == ready1) trigger1 = ~trigger1;
                if (triggerOutRB != readyInRB) begin
                    readyInRB = triggerOutRB;
                    dataInRB  = $urandom;
                end
                @(negedge clk);
            end
            check("rr count", n, 8);
            for (int i = 0; i < n; i++) check($sformatf("rr grant %0d", i), gseq[i], i % 2);
        end

        // Random run against the transaction model.
        do_reset();
        e_trig = 0; e_addr = '0; e_r0 = 0; e_r1 = 0; e_d0 = '0; e_d1 = '0;
        e_g = 0; m_busy = 0; m_last = 1; rb_wait = 0;
        for (int c = 0; c < 3000; c++) begin
            check($sformatf("rnd%0d trig", c), triggerOutRB, e_trig);
            check($sformatf("rnd%0d addr", c), addrRB, e_addr);
            check($sformatf("rnd%0d r0d0", c), {ready0, data0}, {e_r0, e_d0});
            check($sformatf("rnd%0d r1d1", c), {ready1, data1}, {e_r1, e_d1});
            check($sformatf("rnd%0d gb", c), {grant, busy, err}, {e_g, m_busy, 1'b0});
            if (trigger0 == e_r0 && $urandom_range(0, 2) == 0) trigger0 = ~trigger0;
            if (trigger1 == e_r1 && $urandom_range(0, 2) == 0) trigger1 = ~trigger1;
            addr0 = $urandom;
            addr1 = $urandom;
            if (m_busy) begin
                if (rb_wait == 0) begin
                    readyInRB = e_trig;
                    dataInRB  = $urandom;
                end else begin
                    rb_wait--;
                end
            end
            p0 = (trigger0 != e_r0);
            p1 = (trigger1 != e_r1);
            if (!m_busy) begin
                if (p0 || p1) begin
                    g       = (p0 && p1) ? ~m_last : p1;
                    e_g     = g;
                    m_last  = g;
                    e_addr  = g ? addr1 : addr0;
                    e_trig  = ~e_trig;
                    m_busy  = 1'b1;
                    rb_wait = $urandom_range(0, 3);
                end
            end else if (readyInRB == e_trig) begin
                if (e_g) begin e_r1 = ~e_r1; e_d1 = dataInRB; end
                else     begin e_r0 = ~e_r0; e_d0 = dataInRB; end
                m_busy = 1'b0;
            end
            @(negedge clk);
        end

`ifdef REGBANK_ARB_TIMEOUT_EN
        begin
            int wc = 0;
            do_reset();
            trigger0 = 1'b1;
            addr0    = 32'd5;
            @(negedge clk);
            check("to grant", {triggerOutRB, addrRB}, {1'b1, 32'd5});
            while (busy && wc < 20) begin
                wc++;
                @(negedge clk);
            end
            check("to wait cycles", wc, 8);
            check("to ready0", ready0, 1'b1);
            check("to data0", data0, 32'hDEADBEEF);
            check("to err", err, 1'b1);
            trigger1 = 1'b1;
            repeat (5) @(negedge clk);
            check("err trig", triggerOutRB, 1'b1);
            check("err ready1", ready1, 1'b0);
            check("err busy", busy, 1'b0);
            check("err sticky", err, 1'b1);
            do_reset();
            check("err reset", err, 1'b0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
